// File: rtl/game_pkg.sv
// Shared constants and state encoding for the Flappy Bird referee.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned BIRD_W   = 40;
  localparam int unsigned BIRD_H   = 50;
  localparam int unsigned TUBE_W   = 120;
  localparam int unsigned GAP_H    = 250;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND,
    DONE
  } referee_state_t;

endpackage

// File: rtl/bird_tube_hit.sv
// Stage 1 for one bird: find the nearest tube not yet passed and register
// whether the bird collides with it (or with the floor/ceiling).
module bird_tube_hit #(
  parameter int unsigned N_TUBES = 3,
  parameter int unsigned BIRD_X  = 180,
  parameter int unsigned BIRD_W  = 40,
  parameter int unsigned BIRD_H  = 50,
  parameter int unsigned TUBE_W  = 120,
  parameter int unsigned GAP_H   = 250,
  parameter int unsigned IW      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [10:0]            bird_y,
  input  logic                   bound_hit,
  input  logic [11*N_TUBES-1:0]  tube_x,
  input  logic [11*N_TUBES-1:0]  gap_y,
  output logic                   hit_q,
  output logic                   bound_q,
  output logic [IW-1:0]          idx_q
);

  localparam logic [11:0] BX = 12'(BIRD_X);

  logic          found;
  logic [11:0]   tx;
  logic [11:0]   best_x;
  logic [11:0]   best_gap;
  logic [11:0]   by;
  logic          tube_hit;
  logic          hit_d;
  logic          bound_d;
  logic [IW-1:0] idx_d;

  // Active tube search (leftmost tube whose right edge is still ahead of the bird) and collision test
  always_comb begin
    found    = 1'b0;
    tx       = '0;
    best_x   = '1;
    best_gap = '0;
    idx_d    = '0;
    for (int unsigned t = 0; t < N_TUBES; t++) begin
      tx = {1'b0, tube_x[11*t +: 11]};
      if ((tx + 12'(TUBE_W) > BX) && (!found || tx < best_x)) begin
        found    = 1'b1;
        best_x   = tx;
        best_gap = {1'b0, gap_y[11*t +: 11]};
        idx_d    = IW'(t);
      end
    end
    by       = {1'b0, bird_y};
    tube_hit = found && (best_x <= BX + 12'(BIRD_W - 1)) &&
               ((by < best_gap) || (by + 12'(BIRD_H - 1) > best_gap + 12'(GAP_H)));
    hit_d    = bound_hit | tube_hit;
    bound_d  = bound_hit;
  end

  // Stage-1 registers, cleared on round restart
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= 1'b0;
      bound_q <= 1'b0;
      idx_q   <= '0;
    end else if (clr) begin
      hit_q   <= 1'b0;
      bound_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      hit_q   <= hit_d;
      bound_q <= bound_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/game_referee.sv
// N-player Flappy Bird referee: alive tracking, grace window for near-simultaneous
// tube hits and winner resolution. Optional per-bird scoring with GAME_REFEREE_SCORE_EN.
module game_referee #(
  parameter int unsigned N_BIRDS   = 2,
  parameter int unsigned N_TUBES   = 3,
  parameter int unsigned BIRD_X0   = 180,
  parameter int unsigned BIRD_DX   = 80,
  parameter int unsigned BIRD_W    = game_pkg::BIRD_W,
  parameter int unsigned BIRD_H    = game_pkg::BIRD_H,
  parameter int unsigned TUBE_W    = game_pkg::TUBE_W,
  parameter int unsigned GAP_H     = game_pkg::GAP_H,
  parameter int unsigned GRACE_CYC = 2**20,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         game_rst,
  input  logic                         start,
  input  logic [11*N_BIRDS-1:0]        bird_y,
  input  logic [N_BIRDS-1:0]           bound_hit,
  input  logic [11*N_TUBES-1:0]        tube_x,
  input  logic [11*N_TUBES-1:0]        gap_y,
  output logic [N_BIRDS-1:0]           alive,
  output logic                         pending,
  output logic                         winner_valid,
  output logic [N_BIRDS-1:0]           winner_mask,
  output logic [SCORE_W*N_BIRDS-1:0]   score
);
  import game_pkg::*;

  localparam int unsigned IW = (N_TUBES > 1) ? $clog2(N_TUBES) : 1;
  localparam int unsigned TW = $clog2(GRACE_CYC) + 1;

  logic [N_BIRDS-1:0] hit;
  logic [N_BIRDS-1:0] bound_r;
  logic [IW-1:0]      idx_r [N_BIRDS];

  for (genvar gi = 0; gi < N_BIRDS; gi++) begin : g_bird
    bird_tube_hit #(
      .N_TUBES (N_TUBES),
      .BIRD_X  (BIRD_X0 + gi * BIRD_DX),
      .BIRD_W  (BIRD_W),
      .BIRD_H  (BIRD_H),
      .TUBE_W  (TUBE_W),
      .GAP_H   (GAP_H),
      .IW      (IW)
    ) u_hit (
      .clk       (clk),
      .rst       (rst),
      .clr       (game_rst),
      .bird_y    (bird_y[11*gi +: 11]),
      .bound_hit (bound_hit[gi]),
      .tube_x    (tube_x),
      .gap_y     (gap_y),
      .hit_q     (hit[gi]),
      .bound_q   (bound_r[gi]),
      .idx_q     (idx_r[gi])
    );
  end

  referee_state_t        state_q, state_d;
  logic [N_BIRDS-1:0]    alive_q, alive_d;
  logic                  pending_q, pending_d;
  logic                  winner_valid_q, winner_valid_d;
  logic [N_BIRDS-1:0]    winner_mask_q, winner_mask_d;
  logic [N_BIRDS-1:0]    last_kill_q, last_kill_d;
  logic [IW-1:0]         pend_idx_q, pend_idx_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [11*N_TUBES-1:0] tx_prev_q, tx_prev_d;

  logic [N_BIRDS-1:0]    kill, surv, tube_kill;
  logic [IW-1:0]         tk_idx;
  logic                  tk_found;
  int unsigned           n_surv;
  logic [10:0]           ptx, pprev;
  logic                  all_past, close;

  // Referee FSM next state; the tie mask accumulates every kill since the grace window opened
  always_comb begin
    state_d        = state_q;
    alive_d        = alive_q;
    pending_d      = pending_q;
    winner_valid_d = 1'b0;
    winner_mask_d  = winner_mask_q;
    last_kill_d    = last_kill_q;
    pend_idx_d     = pend_idx_q;
    timer_d        = timer_q;
    tx_prev_d      = tube_x;

    kill      = alive_q & hit;
    surv      = alive_q & ~kill;
    tube_kill = kill & ~bound_r;
    n_surv    = 0;
    tk_found  = 1'b0;
    tk_idx    = '0;
    for (int unsigned i = 0; i < N_BIRDS; i++) begin
      if (surv[i]) n_surv++;
      if (tube_kill[i] && !tk_found) begin
        tk_found = 1'b1;
        tk_idx   = idx_r[i];
      end
    end

    ptx   = '0;
    pprev = '0;
    for (int unsigned t = 0; t < N_TUBES; t++) begin
      if (IW'(t) == pend_idx_q) begin
        ptx   = tube_x[11*t +: 11];
        pprev = tx_prev_q[11*t +: 11];
      end
    end
    all_past = 1'b1;
    for (int unsigned i = 0; i < N_BIRDS; i++) begin
      if (surv[i] && (12'(BIRD_X0 + i * BIRD_DX) < {1'b0, ptx} + 12'(TUBE_W))) all_past = 1'b0;
    end
    // a jump to the right means the pending tube wrapped, i.e. everyone passed it
    close = all_past || (ptx > pprev) || (timer_q == TW'(GRACE_CYC - 1));

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (kill != '0) begin
          alive_d = surv;
          if (n_surv == 0) begin
            winner_mask_d  = kill;
            winner_valid_d = 1'b1;
            state_d        = DONE;
          end else if (tube_kill != '0) begin
            state_d     = PEND;
            pending_d   = 1'b1;
            pend_idx_d  = tk_idx;
            timer_d     = '0;
            last_kill_d = kill;
          end else if (n_surv == 1) begin
            winner_mask_d  = surv;
            winner_valid_d = 1'b1;
            state_d        = DONE;
          end
        end
      end
      PEND: begin
        alive_d     = surv;
        last_kill_d = last_kill_q | kill;
        timer_d     = timer_q + TW'(1);
        if (n_surv == 0) begin
          pending_d      = 1'b0;
          winner_mask_d  = last_kill_q | kill;
          winner_valid_d = 1'b1;
          state_d        = DONE;
        end else if (close) begin
          pending_d = 1'b0;
          if (n_surv == 1) begin
            winner_mask_d  = surv;
            winner_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: ;
    endcase

    if (game_rst) begin
      state_d        = IDLE;
      alive_d        = '1;
      pending_d      = 1'b0;
      winner_valid_d = 1'b0;
      winner_mask_d  = '0;
      last_kill_d    = '0;
      pend_idx_d     = '0;
      timer_d        = '0;
    end
  end

  // Referee state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      alive_q        <= '1;
      pending_q      <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_mask_q  <= '0;
      last_kill_q    <= '0;
      pend_idx_q     <= '0;
      timer_q        <= '0;
      tx_prev_q      <= '0;
    end else begin
      state_q        <= state_d;
      alive_q        <= alive_d;
      pending_q      <= pending_d;
      winner_valid_q <= winner_valid_d;
      winner_mask_q  <= winner_mask_d;
      last_kill_q    <= last_kill_d;
      pend_idx_q     <= pend_idx_d;
      timer_q        <= timer_d;
      tx_prev_q      <= tx_prev_d;
    end
  end

  assign alive        = alive_q;
  assign pending      = pending_q;
  assign winner_valid = winner_valid_q;
  assign winner_mask  = winner_mask_q;

`ifdef GAME_REFEREE_SCORE_EN
  logic [N_BIRDS*N_TUBES-1:0] passed_q, passed_d;
  logic [SCORE_W*N_BIRDS-1:0] score_q, score_d;

  // One saturating increment per tube pass; a wrapped tube re-arms its passed bits
  always_comb begin
    passed_d = passed_q;
    score_d  = score_q;
    for (int unsigned t = 0; t < N_TUBES; t++) begin
      for (int unsigned i = 0; i < N_BIRDS; i++) begin
        if (tube_x[11*t +: 11] > tx_prev_q[11*t +: 11]) begin
          passed_d[i*N_TUBES + t] = 1'b0;
        end else if ((state_q == RUN || state_q == PEND) && alive_q[i] &&
                     !passed_q[i*N_TUBES + t] &&
                     (12'(BIRD_X0 + i * BIRD_DX) >= {1'b0, tube_x[11*t +: 11]} + 12'(TUBE_W))) begin
          passed_d[i*N_TUBES + t] = 1'b1;
          if (score_d[SCORE_W*i +: SCORE_W] != '1)
            score_d[SCORE_W*i +: SCORE_W] = score_d[SCORE_W*i +: SCORE_W] + SCORE_W'(1);
        end
      end
    end
    if (game_rst) begin
      passed_d = '0;
      score_d  = '0;
    end
  end

  // Score and passed-tube registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      passed_q <= '0;
      score_q  <= '0;
    end else begin
      passed_q <= passed_d;
      score_q  <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_game_referee.sv
// Directed testbench for game_referee (two instances: 2 birds default, 3 birds short grace).
// Score expectations follow GAME_REFEREE_SCORE_EN.
module tb_game_referee;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_rst;
  logic        a_start, b_start;
  logic [21:0] a_bird_y;
  logic [32:0] b_bird_y;
  logic [1:0]  a_bound;
  logic [2:0]  b_bound;
  logic [32:0] tube_x, gap_y;

  logic [1:0]  a_alive, a_wm;
  logic        a_pending, a_wv;
  logic [15:0] a_score;
  logic [2:0]  b_alive, b_wm;
  logic        b_pending, b_wv;
  logic [5:0]  b_score;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_referee #(.N_BIRDS(2), .N_TUBES(3)) dut_a (
    .clk(clk), .rst(rst), .game_rst(game_rst), .start(a_start),
    .bird_y(a_bird_y), .bound_hit(a_bound), .tube_x(tube_x), .gap_y(gap_y),
    .alive(a_alive), .pending(a_pending), .winner_valid(a_wv),
    .winner_mask(a_wm), .score(a_score)
  );

  game_referee #(.N_BIRDS(3), .N_TUBES(3), .GRACE_CYC(100), .SCORE_W(2)) dut_b (
    .clk(clk), .rst(rst), .game_rst(game_rst), .start(b_start),
    .bird_y(b_bird_y), .bound_hit(b_bound), .tube_x(tube_x), .gap_y(gap_y),
    .alive(b_alive), .pending(b_pending), .winner_valid(b_wv),
    .winner_mask(b_wm), .score(b_score)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tube(input int idx, input int x);
    tube_x[11*idx +: 11] = 11'(x);
  endtask

  task automatic park();
    set_tube(0, 1000); set_tube(1, 1200); set_tube(2, 1400);
    gap_y    = {3{11'd100}};
    a_bird_y = {2{11'd150}};
    b_bird_y = {3{11'd150}};
    a_bound  = '0;
    b_bound  = '0;
  endtask

  task automatic restart(input bit sel_b);
    game_rst = 1'b1; step(); game_rst = 1'b0;
    if (sel_b) b_start = 1'b1; else a_start = 1'b1;
    step();
    a_start = 1'b0; b_start = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    n_checks++; if (a_alive !== 2'b11) begin n_fail++; $display("FAIL reset_alive_a: got %b expected 11", a_alive); end
    n_checks++; if (a_pending !== 1'b0 || a_wv !== 1'b0) begin n_fail++; $display("FAIL reset_flags_a: got pend=%b wv=%b expected 0 0", a_pending, a_wv); end
    n_checks++; if (a_wm !== 2'b00) begin n_fail++; $display("FAIL reset_mask_a: got %b expected 00", a_wm); end
    n_checks++; if (a_score !== 16'h0) begin n_fail++; $display("FAIL reset_score_a: got %h expected 0000", a_score); end
    n_checks++; if (b_alive !== 3'b111) begin n_fail++; $display("FAIL reset_alive_b: got %b expected 111", b_alive); end
  endtask

  task automatic test_bound_win();
    park(); restart(1'b0);
    a_bound = 2'b10; step(); a_bound = 2'b00;
    n_checks++; if (a_alive !== 2'b11) begin n_fail++; $display("FAIL bound_lat1: got %b expected 11", a_alive); end
    step();
    n_checks++; if (a_alive !== 2'b01) begin n_fail++; $display("FAIL bound_alive: got %b expected 01", a_alive); end
    n_checks++; if (a_wv !== 1'b1 || a_wm !== 2'b01) begin n_fail++; $display("FAIL bound_winner: got wv=%b mask=%b expected 1 01", a_wv, a_wm); end
    step();
    n_checks++; if (a_wv !== 1'b0) begin n_fail++; $display("FAIL bound_pulse: got %b expected 0", a_wv); end
    // DONE ignores start and further hits
    a_start = 1'b1; a_bound = 2'b01; step(); a_start = 1'b0; a_bound = 2'b00; step(); step();
    n_checks++; if (a_alive !== 2'b01 || a_wv !== 1'b0 || a_wm !== 2'b01) begin n_fail++; $display("FAIL done_hold: got alive=%b wv=%b mask=%b expected 01 0 01", a_alive, a_wv, a_wm); end
  endtask

  task automatic test_tube_tie();
    park(); set_tube(1, 150); restart(1'b0);
    a_bird_y[10:0] = 11'd50; step(); step();
    n_checks++; if (a_alive !== 2'b10 || a_pending !== 1'b1 || a_wv !== 1'b0) begin n_fail++; $display("FAIL tie_open: got alive=%b pend=%b wv=%b expected 10 1 0", a_alive, a_pending, a_wv); end
    repeat (48) step();
    n_checks++; if (a_pending !== 1'b1) begin n_fail++; $display("FAIL tie_hold: got %b expected 1", a_pending); end
    a_bird_y[21:11] = 11'd50; step(); step();
    n_checks++; if (a_alive !== 2'b00 || a_pending !== 1'b0) begin n_fail++; $display("FAIL tie_close: got alive=%b pend=%b expected 00 0", a_alive, a_pending); end
    n_checks++; if (a_wv !== 1'b1 || a_wm !== 2'b11) begin n_fail++; $display("FAIL tie_mask: got wv=%b mask=%b expected 1 11", a_wv, a_wm); end
  endtask

  task automatic test_tube_clear();
    park(); set_tube(1, 150); restart(1'b0);
    a_bird_y[10:0] = 11'd50; step(); step();
    set_tube(1, 141); step();
    n_checks++; if (a_pending !== 1'b1) begin n_fail++; $display("FAIL clear_edge_minus1: got %b expected 1", a_pending); end
    set_tube(1, 140); step();
    n_checks++; if (a_pending !== 1'b0 || a_wv !== 1'b1) begin n_fail++; $display("FAIL clear_close: got pend=%b wv=%b expected 0 1", a_pending, a_wv); end
    n_checks++; if (a_wm !== 2'b10 || a_alive !== 2'b10) begin n_fail++; $display("FAIL clear_winner: got mask=%b alive=%b expected 10 10", a_wm, a_alive); end
  endtask

  task automatic test_wrap();
    park(); set_tube(1, 150); restart(1'b0);
    a_bird_y[10:0] = 11'd50; step(); step();
    n_checks++; if (a_pending !== 1'b1) begin n_fail++; $display("FAIL wrap_open: got %b expected 1", a_pending); end
    set_tube(1, 1900); step();
    n_checks++; if (a_pending !== 1'b0 || a_wv !== 1'b1 || a_wm !== 2'b10) begin n_fail++; $display("FAIL wrap_close: got pend=%b wv=%b mask=%b expected 0 1 10", a_pending, a_wv, a_wm); end
  endtask

  task automatic test_score();
    logic [15:0] exp1, exp3;
`ifdef GAME_REFEREE_SCORE_EN
    exp1 = 16'h0101; exp3 = 16'h0303;
`else
    exp1 = 16'h0000; exp3 = 16'h0000;
`endif
    park(); restart(1'b0);
    for (int p = 0; p < 3; p++) begin
      set_tube(0, 600); step();
      set_tube(0, 40);  step();
      if (p == 0) begin
        n_checks++; if (a_score !== exp1) begin n_fail++; $display("FAIL score_one: got %h expected %h", a_score, exp1); end
      end
    end
    step(); step();
    n_checks++; if (a_score !== exp3) begin n_fail++; $display("FAIL score_three: got %h expected %h", a_score, exp3); end
  endtask

  task automatic test_grace();
    int n;
    bit saw_wv;
    park(); set_tube(1, 150); restart(1'b1);
    b_bird_y[10:0] = 11'd50; step(); step();
    n_checks++; if (b_pending !== 1'b1 || b_alive !== 3'b110) begin n_fail++; $display("FAIL grace_open: got pend=%b alive=%b expected 1 110", b_pending, b_alive); end
    n = 0; saw_wv = 1'b0;
    while (b_pending === 1'b1 && n < 200) begin
      step(); n++;
      if (b_wv === 1'b1) saw_wv = 1'b1;
    end
    n_checks++; if (n !== 100) begin n_fail++; $display("FAIL grace_len: got %0d cycles expected 100", n); end
    n_checks++; if (saw_wv !== 1'b0 || b_alive !== 3'b110) begin n_fail++; $display("FAIL grace_nowin: got wv_seen=%b alive=%b expected 0 110", saw_wv, b_alive); end
    b_bound = 3'b010; step(); b_bound = 3'b000; step();
    n_checks++; if (b_alive !== 3'b100 || b_wv !== 1'b1 || b_wm !== 3'b100) begin n_fail++; $display("FAIL grace_run: got alive=%b wv=%b mask=%b expected 100 1 100", b_alive, b_wv, b_wm); end
  endtask

  task automatic test_all_hit();
    park(); restart(1'b1);
    b_bound = 3'b111; step(); b_bound = 3'b000; step();
    n_checks++; if (b_alive !== 3'b000 || b_pending !== 1'b0) begin n_fail++; $display("FAIL allhit_alive: got alive=%b pend=%b expected 000 0", b_alive, b_pending); end
    n_checks++; if (b_wv !== 1'b1 || b_wm !== 3'b111) begin n_fail++; $display("FAIL allhit_tie: got wv=%b mask=%b expected 1 111", b_wv, b_wm); end
  endtask

  task automatic test_rst_mid_pend();
    park(); set_tube(1, 150); restart(1'b1);
    b_bird_y[10:0] = 11'd50; step(); step();
    n_checks++; if (b_pending !== 1'b1) begin n_fail++; $display("FAIL rst_pend_open: got %b expected 1", b_pending); end
    rst = 1'b1; #2;
    n_checks++; if (b_alive !== 3'b111 || b_pending !== 1'b0 || b_wm !== 3'b000) begin n_fail++; $display("FAIL rst_async: got alive=%b pend=%b mask=%b expected 111 0 000", b_alive, b_pending, b_wm); end
    #2 rst = 1'b0;
    park(); step();
  endtask

  task automatic test_score_sat();
    logic [5:0] exp_sat;
`ifdef GAME_REFEREE_SCORE_EN
    exp_sat = 6'h3F;
`else
    exp_sat = 6'h00;
`endif
    park(); restart(1'b1);
    for (int p = 0; p < 5; p++) begin
      set_tube(0, 600); step();
      set_tube(0, 40);  step();
      if (p == 3) begin
        n_checks++; if (b_score !== exp_sat) begin n_fail++; $display("FAIL score_sat4: got %h expected %h", b_score, exp_sat); end
      end
    end
    n_checks++; if (b_score !== exp_sat) begin n_fail++; $display("FAIL score_sat5: got %h expected %h", b_score, exp_sat); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; game_rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
    tube_x = '0;
    park();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_bound_win();
    test_tube_tie();
    test_tube_clear();
    test_wrap();
    test_score();
    test_grace();
    test_all_hit();
    test_rst_mid_pend();
    test_score_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
